// File: rtl/fragment_collector_if.sv
// Fragment-in / word-out handshake bundle for fragment_collector.
// master = producer/consumer side, slave = the collector.
interface fragment_collector_if #(
  parameter int WIRE = 3,
  parameter int BUS  = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2**WIRE-1:0]        in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [2**(BUS+WIRE)-1:0]  out_data;
  logic [BUS:0]              out_fill;

  modport master (
    output in_valid, in_data, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_fill
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_fill
  );
endinterface

// File: rtl/fragment_collector.sv
// Packs serial 2**WIRE-bit fragments into a 2**(BUS+WIRE)-bit word.
// Fragment 0 lands in the least significant slot.
module fragment_collector #(
  parameter int WIRE = 3,
  parameter int BUS  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  fragment_collector_if.slave bus
);
  localparam int N  = 2**BUS;
  localparam int FW = 2**WIRE;
  localparam int DW = 2**(BUS+WIRE);

  logic [BUS-1:0] idx_q;
  logic [DW-1:0]  asm_q;
  logic [DW-1:0]  data_q;
  logic [BUS:0]   fill_q;
  logic           valid_q;

  logic           in_ready;
  logic           accept;
  logic           complete;
  logic [DW-1:0]  word_d;
  logic [BUS:0]   fill_d;

  assign in_ready = rst_n & (~valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign complete = (idx_q == BUS'(N-1)) | bus.in_last;
  assign fill_d   = {1'b0, idx_q} + {{BUS{1'b0}}, 1'b1};

  // Slots above idx are forced to zero so an early close is clean.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(idx_q))
        word_d[k*FW +: FW] = asm_q[k*FW +: FW];
      else if (k == int'(idx_q))
        word_d[k*FW +: FW] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && bus.out_ready)
        valid_q <= 1'b0;
      if (accept) begin
        if (complete) begin
          data_q  <= word_d;
          fill_q  <= fill_d;
          valid_q <= 1'b1;
          idx_q   <= '0;
          asm_q   <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
          asm_q <= word_d;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_fill  = fill_q;
endmodule

// File: tb/tb_fragment_collector.sv
// Scoreboard bench for fragment_collector (WIRE=3, BUS=1).
// Directed fragments push expected words; a monitor pops on handshake.
module tb_fragment_collector;
  localparam int WIRE = 3;
  localparam int BUS  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fragment_collector_if #(.WIRE(WIRE), .BUS(BUS)) bus ();

  fragment_collector #(.WIRE(WIRE), .BUS(BUS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  int stalls = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] d,
                             input logic [1:0] f);
    sb.push_back({f, d});
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    logic acc;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic monitor();
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h, expected none",
                   bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("word_data", 32'(bus.out_data), 32'(e[15:0]));
          chk("word_fill", 32'(bus.out_fill), 32'(e[17:16]));
        end
      end
    end
  endtask

  initial begin
    int s0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_fill", 32'(bus.out_fill), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // basic assembly
    bus.out_ready = 1'b1;
    expect_word(16'hB4AA, 2'd2);
    send(8'hAA, 1'b0);
    send(8'hB4, 1'b0);
    chk("basic_valid", 32'(bus.out_valid), 1);
    idle(2);

    // early close
    expect_word(16'h0055, 2'd1);
    send(8'h55, 1'b1);
    chk("early_fill", 32'(bus.out_fill), 1);
    idle(2);

    // backpressure
    bus.out_ready = 1'b0;
    expect_word(16'h1234, 2'd2);
    expect_word(16'h8877, 2'd2);
    send(8'h34, 1'b0);
    send(8'h12, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_data", 32'(bus.out_data), 32'h1234);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    s0 = stalls;
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    chk("bp_release_stalls", 32'(stalls - s0), 0);
    idle(2);

    // streaming
    expect_word(16'h0201, 2'd2);
    expect_word(16'h0403, 2'd2);
    s0 = stalls;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("stream_stalls", 32'(stalls - s0), 0);
    idle(2);

    // consume and complete on the same edge
    expect_word(16'h0066, 2'd1);
    expect_word(16'h0077, 2'd1);
    s0 = stalls;
    send(8'h66, 1'b1);
    send(8'h77, 1'b1);
    chk("overlap_valid", 32'(bus.out_valid), 1);
    chk("overlap_data", 32'(bus.out_data), 32'h0077);
    chk("overlap_stalls", 32'(stalls - s0), 0);
    idle(2);

    // reset mid-word
    send(8'hAA, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("rstmid_out_valid", 32'(bus.out_valid), 0);
    chk("rstmid_out_data", 32'(bus.out_data), 0);
    chk("rstmid_out_fill", 32'(bus.out_fill), 0);
    rst_n = 1'b1;
    expect_word(16'h2211, 2'd2);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    idle(2);

    // reset with pending output
    bus.out_ready = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hB4, 1'b0);
    idle(1);
    chk("pend_valid", 32'(bus.out_valid), 1);
    chk("pend_data", 32'(bus.out_data), 32'hB4AA);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("pendrst_valid", 32'(bus.out_valid), 0);
    chk("pendrst_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(4);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
